// File: rtl/lock_pkg.sv
// Shared state encoding, blink request codes and default key codes for the
// keypad code lock.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_UNLOCKED,
        ST_PROGRAM,
        ST_LOCKOUT
    } lock_state_e;

    localparam logic [1:0] BLINK_ACCEPT     = 2'd0;
    localparam logic [1:0] BLINK_REJECT     = 2'd1;
    localparam logic [1:0] BLINK_LOCKOUT    = 2'd2;
    localparam logic [1:0] BLINK_PROGRAMMED = 2'd3;

    localparam logic [3:0] DEFAULT_ENTER_KEY = 4'd11;
    localparam logic [3:0] DEFAULT_CLEAR_KEY = 4'd10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_sync.sv
// Brings the scanner's key-held flag into the hwclk domain and turns each key
// release into a single-cycle event carrying the key code.
module key_event_sync #(
    parameter int DIGIT_W = 4
) (
    input  logic               hwclk,
    input  logic               rst_n,
    input  logic               bstate,
    input  logic [DIGIT_W-1:0] button,
    output logic               key_valid,
    output logic [DIGIT_W-1:0] key_code
);

    logic               sync1_q;
    logic               sync2_q;
    logic               prev_q;
    logic [DIGIT_W-1:0] code_q;

    // button is held stable for several cycles after the release, so sampling
    // it every cycle gives a valid code in the cycle the release is seen.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            sync1_q <= bstate;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            code_q  <= button;
        end
    end

    assign key_valid = prev_q & ~sync2_q;
    assign key_code  = code_q;

endmodule

// File: rtl/keypad_code_lock.sv
// Multi-digit code entry controller: collects key events, checks them against a
// reprogrammable code, enforces a retry limit with lockout and requests blinks.
module keypad_code_lock
    import lock_pkg::*;
#(
    parameter int                          CODE_LEN       = 4,
    parameter int                          DIGIT_W        = 4,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          LOCKOUT_CYCLES = 36_000_000,
    parameter int                          UNLOCK_CYCLES  = 60_000_000,
    parameter logic [DIGIT_W-1:0]          ENTER_KEY      = DIGIT_W'(DEFAULT_ENTER_KEY),
    parameter logic [DIGIT_W-1:0]          CLEAR_KEY      = DIGIT_W'(DEFAULT_CLEAR_KEY),
    parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE     = {4'd1, 4'd2, 4'd3, 4'd4}
) (
    input  logic                              hwclk,
    input  logic                              rst_n,
    input  logic [DIGIT_W-1:0]                button,
    input  logic                              bstate,
    input  logic                              prog_en,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]     entry_count,
    output logic                              error,
    output logic                              blink_start,
    output logic [1:0]                        blink_type
);

    localparam int CNT_W = $clog2(CODE_LEN + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(max_int(LOCKOUT_CYCLES, UNLOCK_CYCLES) + 1);
    localparam int BUF_W = CODE_LEN * DIGIT_W;

    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(CODE_LEN);
    localparam logic [TRY_W-1:0] LAST_TRY     = TRY_W'(MAX_TRIES - 1);

    logic               key_valid;
    logic [DIGIT_W-1:0] key_code;

    lock_state_e        state_q;
    logic [BUF_W-1:0]   buf_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic [TRY_W-1:0]   tries_q;
    logic [TMR_W-1:0]   timer_q;
    logic [BUF_W-1:0]   code_q;
    logic               unlocked_q;
    logic               locked_out_q;
    logic               error_q;
    logic               blink_start_q;
    logic [1:0]         blink_type_q;

    logic [BUF_W-1:0]   buf_d;
    logic [CNT_W-1:0]   count_d;
    logic               overflow_d;
    logic               is_enter;
    logic               is_clear;
    logic               entry_full;
    logic               code_match;
    logic               timer_done;

    key_event_sync #(
        .DIGIT_W (DIGIT_W)
    ) u_key_sync (
        .hwclk     (hwclk),
        .rst_n     (rst_n),
        .bstate    (bstate),
        .button    (button),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // Entry buffer after appending the current key; digits past CODE_LEN keep
    // shifting but poison the entry through the overflow flag.
    always_comb begin
        buf_d      = (buf_q << DIGIT_W) | BUF_W'(key_code);
        count_d    = (count_q == FULL_COUNT) ? count_q : count_q + CNT_W'(1);
        overflow_d = overflow_q | (count_q == FULL_COUNT);
        is_enter   = (key_code == ENTER_KEY);
        is_clear   = (key_code == CLEAR_KEY);
        entry_full = (count_q == FULL_COUNT) && !overflow_q;
        code_match = entry_full && (buf_q == code_q);
        timer_done = (timer_q == '0);
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            buf_q         <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            tries_q       <= '0;
            timer_q       <= '0;
            code_q        <= RESET_CODE;
            unlocked_q    <= 1'b0;
            locked_out_q  <= 1'b0;
            error_q       <= 1'b0;
            blink_start_q <= 1'b0;
            blink_type_q  <= BLINK_ACCEPT;
        end else begin
            error_q       <= 1'b0;
            blink_start_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (key_valid) begin
                        if (is_enter) begin
                            state_q <= ST_CHECK;
                        end else if (is_clear) begin
                            buf_q      <= '0;
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                        end else begin
                            buf_q      <= buf_d;
                            count_q    <= count_d;
                            overflow_q <= overflow_d;
                        end
                    end
                end

                ST_CHECK: begin
                    buf_q         <= '0;
                    count_q       <= '0;
                    overflow_q    <= 1'b0;
                    blink_start_q <= 1'b1;
                    if (code_match) begin
                        state_q      <= ST_UNLOCKED;
                        unlocked_q   <= 1'b1;
                        timer_q      <= UNLOCK_LOAD;
                        tries_q      <= '0;
                        blink_type_q <= BLINK_ACCEPT;
                    end else begin
                        error_q <= 1'b1;
                        tries_q <= tries_q + TRY_W'(1);
                        if (tries_q == LAST_TRY) begin
                            state_q      <= ST_LOCKOUT;
                            locked_out_q <= 1'b1;
                            timer_q      <= LOCKOUT_LOAD;
                            blink_type_q <= BLINK_LOCKOUT;
                        end else begin
                            state_q      <= ST_IDLE;
                            blink_type_q <= BLINK_REJECT;
                        end
                    end
                end

                // Expiry is tested before the key so a coincident key is dropped.
                ST_UNLOCKED: begin
                    if (timer_done) begin
                        state_q    <= ST_IDLE;
                        unlocked_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                        if (key_valid && is_enter) begin
                            state_q    <= ST_IDLE;
                            unlocked_q <= 1'b0;
                        end else if (key_valid && is_clear && prog_en) begin
                            state_q    <= ST_PROGRAM;
                            unlocked_q <= 1'b0;
                            buf_q      <= '0;
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                        end
                    end
                end

                ST_PROGRAM: begin
                    if (!prog_en || (key_valid && is_enter && !entry_full)) begin
                        state_q    <= ST_UNLOCKED;
                        unlocked_q <= 1'b1;
                        timer_q    <= UNLOCK_LOAD;
                        error_q    <= 1'b1;
                        buf_q      <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end else if (key_valid) begin
                        if (is_enter) begin
                            state_q       <= ST_IDLE;
                            code_q        <= buf_q;
                            blink_start_q <= 1'b1;
                            blink_type_q  <= BLINK_PROGRAMMED;
                            buf_q         <= '0;
                            count_q       <= '0;
                            overflow_q    <= 1'b0;
                        end else if (is_clear) begin
                            buf_q      <= '0;
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                        end else begin
                            buf_q      <= buf_d;
                            count_q    <= count_d;
                            overflow_q <= overflow_d;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (timer_done) begin
                        state_q      <= ST_IDLE;
                        locked_out_q <= 1'b0;
                        tries_q      <= '0;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign unlocked    = unlocked_q;
    assign locked_out  = locked_out_q;
    assign entry_count = count_q;
    assign error       = error_q;
    assign blink_start = blink_start_q;
    assign blink_type  = blink_type_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed and randomized key sequences for keypad_code_lock, checked against a
// digit-queue reference model that tracks timer deadlines as absolute cycles.
module tb_keypad_code_lock;

    localparam int CODE_LEN       = 4;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 20;
    localparam int UNLOCK_CYCLES  = 30;
    localparam int KEY_ENTER      = 11;
    localparam int KEY_CLEAR      = 10;

    logic       hwclk   = 1'b0;
    logic       rst_n   = 1'b0;
    logic       bstate  = 1'b0;
    logic       prog_en = 1'b0;
    logic [3:0] button  = 4'd0;
    logic       unlocked;
    logic       locked_out;
    logic [2:0] entry_count;
    logic       error;
    logic       blink_start;
    logic [1:0] blink_type;

    keypad_code_lock #(
        .CODE_LEN       (CODE_LEN),
        .DIGIT_W        (4),
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .ENTER_KEY      (4'd11),
        .CLEAR_KEY      (4'd10),
        .RESET_CODE     (16'h1234)
    ) dut (
        .hwclk       (hwclk),
        .rst_n       (rst_n),
        .button      (button),
        .bstate      (bstate),
        .prog_en     (prog_en),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .entry_count (entry_count),
        .error       (error),
        .blink_start (blink_start),
        .blink_type  (blink_type)
    );

    always #5 hwclk = ~hwclk;

    int cyc = 0;
    always @(posedge hwclk) cyc <= cyc + 1;

    // Pulse monitor: counts error pulses and records every blink request.
    int errSeen   = 0;
    int blinkSeen = 0;
    int blinkTypeQ[$];
    always @(negedge hwclk) begin
        if (error === 1'b1) errSeen <= errSeen + 1;
        if (blink_start === 1'b1) begin
            blinkSeen <= blinkSeen + 1;
            blinkTypeQ.push_back(int'(blink_type));
        end
    end

    typedef enum {M_IDLE, M_UNLOCKED, M_PROGRAM, M_LOCKOUT} mode_e;
    mode_e mMode;
    int    mDigits[$];
    int    mCode[CODE_LEN];
    int    mTries;
    int    mDeadline;
    bit    mProg;
    int    errExp    = 0;
    int    blinkExp  = 0;
    int    blinkExpQ[$];
    int    checks    = 0;
    int    passes    = 0;
    int    fails     = 0;
    int    seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        mMode = M_IDLE;
        mDigits.delete();
        mCode = '{1, 2, 3, 4};
        mTries = 0;
        mDeadline = 0;
    endtask

    task automatic settleTo(input int edgeNo);
        if ((mMode == M_UNLOCKED || mMode == M_LOCKOUT) && edgeNo >= mDeadline) begin
            if (mMode == M_LOCKOUT) mTries = 0;
            mMode = M_IDLE;
        end
    endtask

    function automatic bit codeMatches();
        if (mDigits.size() != CODE_LEN) return 1'b0;
        for (int i = 0; i < CODE_LEN; i++)
            if (mDigits[i] != mCode[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic expectBlink(input int t);
        blinkExp++;
        blinkExpQ.push_back(t);
    endtask

    // Key k is acted on at edge h; a check result lands one edge later.
    task automatic modelKey(input int k, input int h);
        bit dropped;
        if ((mMode == M_UNLOCKED || mMode == M_LOCKOUT) && mDeadline <= h) begin
            dropped = (mDeadline == h);
            settleTo(h);
            if (dropped) return;
        end
        case (mMode)
            M_IDLE: begin
                if (k == KEY_ENTER) begin
                    if (codeMatches()) begin
                        mMode = M_UNLOCKED;
                        mDeadline = h + 1 + UNLOCK_CYCLES;
                        mTries = 0;
                        expectBlink(0);
                    end else begin
                        mTries++;
                        errExp++;
                        if (mTries >= MAX_TRIES) begin
                            mMode = M_LOCKOUT;
                            mDeadline = h + 1 + LOCKOUT_CYCLES;
                            expectBlink(2);
                        end else begin
                            expectBlink(1);
                        end
                    end
                    mDigits.delete();
                end else if (k == KEY_CLEAR) begin
                    mDigits.delete();
                end else begin
                    mDigits.push_back(k);
                end
            end
            M_UNLOCKED: begin
                if (k == KEY_ENTER) begin
                    mMode = M_IDLE;
                end else if (k == KEY_CLEAR && mProg) begin
                    mMode = M_PROGRAM;
                    mDigits.delete();
                end
            end
            M_PROGRAM: begin
                if (k == KEY_ENTER) begin
                    if (mDigits.size() == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) mCode[i] = mDigits[i];
                        expectBlink(3);
                        mMode = M_IDLE;
                    end else begin
                        errExp++;
                        mMode = M_UNLOCKED;
                        mDeadline = h + UNLOCK_CYCLES;
                    end
                    mDigits.delete();
                end else if (k == KEY_CLEAR) begin
                    mDigits.delete();
                end else begin
                    mDigits.push_back(k);
                end
            end
            default: begin
            end
        endcase
    endtask

    task automatic checkOutput(input string tag);
        int expCount;
        settleTo(cyc);
        expCount = (mDigits.size() > CODE_LEN) ? CODE_LEN : mDigits.size();
        check({tag, ".unlocked"}, unlocked, mMode == M_UNLOCKED);
        check({tag, ".locked_out"}, locked_out, mMode == M_LOCKOUT);
        check({tag, ".entry_count"}, entry_count, expCount);
        check({tag, ".errors"}, errSeen, errExp);
        check({tag, ".blinks"}, blinkSeen, blinkExp);
        while (blinkTypeQ.size() > 0 && blinkExpQ.size() > 0)
            check({tag, ".blink_type"}, blinkTypeQ.pop_front(), blinkExpQ.pop_front());
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, ".unlocked"}, unlocked, 0);
        check({tag, ".locked_out"}, locked_out, 0);
        check({tag, ".entry_count"}, entry_count, 0);
        check({tag, ".error"}, error, 0);
        check({tag, ".blink_start"}, blink_start, 0);
        check({tag, ".blink_type"}, blink_type, 0);
    endtask

    // Hold the key for two cycles, release, and return one edge after it is handled.
    task automatic applyStimulus(input int k);
        int h;
        @(posedge hwclk);
        #1;
        button = 4'(k);
        bstate = 1'b1;
        repeat (2) @(posedge hwclk);
        #1 bstate = 1'b0;
        h = cyc + 3;
        modelKey(k, h);
        repeat (4) @(posedge hwclk);
        @(negedge hwclk);
        #1;
    endtask

    task automatic keySeq(input string tag, input int keys[$]);
        foreach (keys[i]) begin
            applyStimulus(keys[i]);
            checkOutput(tag);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge hwclk);
        @(negedge hwclk);
        #1;
    endtask

    task automatic setProg(input bit v);
        int r;
        @(posedge hwclk);
        #1 prog_en = v;
        r = cyc + 1;
        settleTo(r);
        mProg = v;
        if (mMode == M_PROGRAM && !v) begin
            errExp++;
            mMode = M_UNLOCKED;
            mDeadline = r + UNLOCK_CYCLES;
            mDigits.delete();
        end
        @(posedge hwclk);
        @(negedge hwclk);
        #1;
    endtask

    task automatic pulseReset(input string tag);
        @(negedge hwclk);
        #2 rst_n = 1'b0;
        #1 checkZeroOutputs(tag);
        bstate = 1'b0;
        button = 4'd0;
        repeat (2) @(posedge hwclk);
        #1 rst_n = 1'b1;
        modelReset();
        @(negedge hwclk);
        #1 checkOutput({tag, ".after"});
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int r;
        modelReset();
        mProg = 1'b0;

        #3 checkZeroOutputs("reset");
        repeat (2) @(posedge hwclk);
        #1 rst_n = 1'b1;
        @(negedge hwclk);
        #1 checkOutput("afterReset");

        // Correct code unlocks, then relocks after exactly UNLOCK_CYCLES.
        seq = '{1, 2, 3, 4, KEY_ENTER};
        keySeq("unlock", seq);
        for (int i = 0; i < UNLOCK_CYCLES + 2; i++) begin
            waitCycles(1);
            checkOutput("unlockDwell");
        end

        // Three wrong codes lead to lockout; keys are ignored while locked out.
        seq = '{1, 2, 3, 5, KEY_ENTER};
        for (int t = 0; t < MAX_TRIES; t++) keySeq("wrong", seq);
        seq = '{1, 2};
        keySeq("lockedKeys", seq);
        for (int i = 0; i < LOCKOUT_CYCLES; i++) begin
            waitCycles(1);
            checkOutput("lockoutDwell");
        end
        seq = '{4, KEY_CLEAR};
        keySeq("afterLockout", seq);

        // Fifth digit overflows the entry.
        seq = '{1, 2, 3, 4, 5, KEY_ENTER};
        keySeq("overflow", seq);

        // Reprogram to 9876 and verify old and new codes.
        seq = '{1, 2, 3, 4, KEY_ENTER};
        keySeq("unlock2", seq);
        setProg(1'b1);
        checkOutput("progOn");
        seq = '{KEY_CLEAR, 9, 8, 7, 6, KEY_ENTER};
        keySeq("program", seq);
        seq = '{9, 8, 7, 6, KEY_ENTER, KEY_ENTER};
        keySeq("newCode", seq);
        seq = '{1, 2, 3, 4, KEY_ENTER};
        keySeq("oldCode", seq);

        // Short programming entry and prog_en falling are both rejected.
        seq = '{9, 8, 7, 6, KEY_ENTER, KEY_CLEAR, 1, 2, 3, KEY_ENTER};
        keySeq("shortProg", seq);
        seq = '{KEY_CLEAR, 5};
        keySeq("progAgain", seq);
        setProg(1'b0);
        checkOutput("progDrop");
        seq = '{KEY_ENTER, 9, 8, 7, 6, KEY_ENTER, KEY_ENTER};
        keySeq("codeKept", seq);

        // Reset during PROGRAM restores the reset code.
        setProg(1'b1);
        seq = '{9, 8, 7, 6, KEY_ENTER, KEY_CLEAR, 5};
        keySeq("toProgram", seq);
        pulseReset("resetProgram");
        seq = '{1, 2, 3, 4, KEY_ENTER, KEY_ENTER};
        keySeq("revert1", seq);

        // Reset during LOCKOUT.
        seq = '{1, 1, 1, 1, KEY_ENTER};
        for (int t = 0; t < MAX_TRIES; t++) keySeq("toLockout", seq);
        pulseReset("resetLockout");
        seq = '{1, 2, 3, 4, KEY_ENTER, KEY_ENTER};
        keySeq("revert2", seq);

        // Randomized phase against the model.
        for (int s = 0; s < 200; s++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                seq.delete();
                for (int i = 0; i < CODE_LEN; i++) seq.push_back(mCode[i]);
                seq.push_back(KEY_ENTER);
                keySeq("rndCode", seq);
            end else if (r < 7) begin
                applyStimulus(int'($urandom_range(0, 15)));
                checkOutput("rndKey");
            end else if (r < 9) begin
                waitCycles(int'($urandom_range(1, 35)));
                checkOutput("rndWait");
            end else begin
                setProg(1'($urandom_range(0, 1)));
                checkOutput("rndProg");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
